// File: rtl/sequence_checker.sv
// sequence_checker
//
// Receive-side monitor for a 4-bit Johnson counter stream. The legal sequence is
// 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, which then wraps to 0000.
//
// The checker first looks for any legal value (HUNT). It then confirms the stream
// with LOCK_COUNT consecutive in-sequence samples (ACQ) before it declares lock
// (LOCKED). While locked, every out-of-sequence sample raises a one-cycle error
// pulse and bumps a saturating error counter. MISS_LIMIT consecutive misses drop
// the lock.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   in_valid   in   in_data holds a sample this cycle
//   in_data    in   [3:0] counter value under check
//   locked     out  1 while in LOCKED (registered)
//   seq_err    out  one-cycle pulse per mismatch while LOCKED (registered)
//   err_count  out  [ERR_W-1:0] saturating mismatch count, cleared only by reset
//   expected   out  [3:0] next expected value, 0000 in HUNT
//
// Optional feature, enabled by defining SEQ_CHK_STICKY_EN:
//   err_clr    in   clears err_sticky at a posedge
//   err_sticky out  set by any error pulse and held until err_clr (set wins)

module sequence_checker #(
    parameter int unsigned LOCK_COUNT = 4,  // legal 1..8
    parameter int unsigned MISS_LIMIT = 2,  // legal 1..15
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
`ifdef SEQ_CHK_STICKY_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       expected
);

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
    localparam logic [3:0] MissLim = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {StHunt, StAcq, StLocked} state_e;

    state_e           state_q, state_d;
    logic [2:0]       exp_idx_q, exp_idx_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [3:0]       expected_q, expected_d;

    // Index to sequence value.
    function automatic logic [3:0] seq_val(input logic [2:0] idx);
        logic [3:0] v;
        unique case (idx)
            3'd0: v = 4'b0000;
            3'd1: v = 4'b0001;
            3'd2: v = 4'b0011;
            3'd3: v = 4'b0111;
            3'd4: v = 4'b1111;
            3'd5: v = 4'b1110;
            3'd6: v = 4'b1100;
            default: v = 4'b1000;
        endcase
        return v;
    endfunction

    // Reverse lookup: sequence value to index, plus membership flag.
    logic       in_member;
    logic [2:0] in_idx;

    always_comb begin
        in_member = 1'b1;
        in_idx    = 3'd0;
        case (in_data)
            4'b0000: in_idx = 3'd0;
            4'b0001: in_idx = 3'd1;
            4'b0011: in_idx = 3'd2;
            4'b0111: in_idx = 3'd3;
            4'b1111: in_idx = 3'd4;
            4'b1110: in_idx = 3'd5;
            4'b1100: in_idx = 3'd6;
            4'b1000: in_idx = 3'd7;
            default: in_member = 1'b0;
        endcase
    end

    logic in_match;
    assign in_match = (in_data == seq_val(exp_idx_q));

    always_comb begin
        state_d     = state_q;
        exp_idx_d   = exp_idx_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_count_d = err_count_q;
        seq_err_d   = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (in_member) begin
                        // Seed from the sample itself; it counts as the first good one.
                        exp_idx_d  = in_idx + 3'd1;
                        good_cnt_d = 4'd1;
                        miss_cnt_d = 4'd0;
                        state_d    = (LOCK_COUNT == 1) ? StLocked : StAcq;
                    end
                end
                StAcq: begin
                    if (in_match) begin
                        exp_idx_d  = exp_idx_q + 3'd1;
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_d == LockCnt) begin
                            state_d    = StLocked;
                            miss_cnt_d = 4'd0;
                        end
                    end else begin
                        // Mismatch during acquisition is discarded, not used as a seed.
                        state_d   = StHunt;
                        exp_idx_d = 3'd0;
                    end
                end
                StLocked: begin
                    if (in_match) begin
                        exp_idx_d  = exp_idx_q + 3'd1;
                        miss_cnt_d = 4'd0;
                    end else begin
                        seq_err_d  = 1'b1;
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (miss_cnt_d == MissLim) begin
                            state_d   = StHunt;
                            exp_idx_d = 3'd0;
                        end else begin
                            // Treat the sample as corrupted; the source kept counting.
                            exp_idx_d = exp_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d   = StHunt;
                    exp_idx_d = 3'd0;
                end
            endcase
        end

        locked_d   = (state_d == StLocked);
        expected_d = (state_d == StHunt) ? 4'b0000 : seq_val(exp_idx_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StHunt;
            exp_idx_q   <= 3'd0;
            good_cnt_q  <= 4'd0;
            miss_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
            expected_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            exp_idx_q   <= exp_idx_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
            expected_q  <= expected_d;
        end
    end

    assign locked    = locked_q;
    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;

`ifdef SEQ_CHK_STICKY_EN
    logic err_sticky_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_sticky_q <= 1'b0;
        end else if (seq_err_d) begin
            err_sticky_q <= 1'b1;
        end else if (err_clr) begin
            err_sticky_q <= 1'b0;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// Testbench for sequence_checker. A driver applies directed and random samples,
// advances a reference model and queues the expected registered outputs. A monitor
// pops one entry after each clock edge and compares it against the DUT outputs.
// The DUT is built with ERR_W=2 so counter saturation is reachable.

module tb_sequence_checker;

    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned MISS_LIMIT = 2;
    localparam int unsigned ERR_W      = 2;
    localparam int          ERR_MAX    = (1 << ERR_W) - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [3:0]       in_data;
    logic             locked;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       expected;
    logic             err_clr;
    logic             err_sticky;

    sequence_checker #(
        .LOCK_COUNT(LOCK_COUNT),
        .MISS_LIMIT(MISS_LIMIT),
        .ERR_W     (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef SEQ_CHK_STICKY_EN
        .err_clr   (err_clr),
        .err_sticky(err_sticky),
`endif
        .locked    (locked),
        .seq_err   (seq_err),
        .err_count (err_count),
        .expected  (expected)
    );

`ifndef SEQ_CHK_STICKY_EN
    assign err_sticky = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lck;
        logic       err;
        int         cnt;
        logic [3:0] expv;
        logic       stk;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: mode 0=hunt, 1=acquiring, 2=locked.
    logic [3:0] seq_tab [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    int m_mode, m_idx, m_good, m_miss, m_cnt;
    logic m_stk;

    function automatic int find_idx(input logic [3:0] d);
        for (int k = 0; k < 8; k++) begin
            if (seq_tab[k] == d) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst_n, input logic vld, input logic [3:0] d,
                              input logic clr);
        exp_t e;
        logic err;
        int   k;
        err = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_good = 0; m_miss = 0; m_cnt = 0; m_stk = 1'b0;
        end else begin
            if (vld) begin
                if (m_mode == 0) begin
                    k = find_idx(d);
                    if (k >= 0) begin
                        m_idx  = (k + 1) % 8;
                        m_good = 1;
                        m_miss = 0;
                        m_mode = (LOCK_COUNT == 1) ? 2 : 1;
                    end
                end else if (m_mode == 1) begin
                    if (d == seq_tab[m_idx]) begin
                        m_idx  = (m_idx + 1) % 8;
                        m_good = m_good + 1;
                        if (m_good == LOCK_COUNT) begin
                            m_mode = 2;
                            m_miss = 0;
                        end
                    end else begin
                        m_mode = 0;
                        m_idx  = 0;
                    end
                end else begin
                    if (d == seq_tab[m_idx]) begin
                        m_idx  = (m_idx + 1) % 8;
                        m_miss = 0;
                    end else begin
                        err    = 1'b1;
                        m_cnt  = (m_cnt < ERR_MAX) ? m_cnt + 1 : ERR_MAX;
                        m_miss = m_miss + 1;
                        if (m_miss == MISS_LIMIT) begin
                            m_mode = 0;
                            m_idx  = 0;
                        end else begin
                            m_idx = (m_idx + 1) % 8;
                        end
                    end
                end
            end
            if (err) m_stk = 1'b1;
            else if (clr) m_stk = 1'b0;
        end
        e.lck  = (m_mode == 2);
        e.err  = err;
        e.cnt  = m_cnt;
        e.expv = (m_mode == 0) ? 4'h0 : seq_tab[m_idx];
`ifdef SEQ_CHK_STICKY_EN
        e.stk  = m_stk;
`else
        e.stk  = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus on the falling edge.
    task automatic step(input logic rst_n, input logic vld, input logic [3:0] d,
                        input logic clr = 1'b0);
        @(negedge clk);
        reset    = rst_n;
        in_valid = vld;
        in_data  = d;
        err_clr  = clr;
        model_step(rst_n, vld, d, clr);
    endtask

    task automatic send(input logic [3:0] d);
        step(1'b1, 1'b1, d);
    endtask

    task automatic gap();
        step(1'b1, 1'b0, 4'hA);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("locked", int'(locked), int'(e.lck));
            cmp("seq_err", int'(seq_err), int'(e.err));
            cmp("err_count", int'(err_count), e.cnt);
            cmp("expected", int'(expected), int'(e.expv));
`ifdef SEQ_CHK_STICKY_EN
            cmp("err_sticky", int'(err_sticky), int'(e.stk));
`endif
        end
    end

    initial begin
        int src;
        logic v;
        logic [3:0] d;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        err_clr  = 1'b0;
        m_mode = 0; m_idx = 0; m_good = 0; m_miss = 0; m_cnt = 0; m_stk = 1'b0;

        // Reset for two cycles, then acquire.
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        send(4'h0); send(4'h1); send(4'h3); send(4'h7);
        // Wrap while locked.
        send(4'hF); send(4'hE); send(4'hC); send(4'h8); send(4'h0); send(4'h1);
        // Single glitch while expecting 1111.
        send(4'h3); send(4'h7); send(4'h5); send(4'hE);
        // Realign to expecting 1111, then lose lock and relock.
        send(4'hC); send(4'h8); send(4'h0); send(4'h1); send(4'h3); send(4'h7);
        send(4'h5); send(4'h5);
        send(4'h7); send(4'hF); send(4'hE); send(4'hC);
        // Gaps with garbage during acquisition and lock; non-member in hunt.
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'hB);
        send(4'h0); gap(); send(4'h1); gap(); gap(); send(4'h3); send(4'h7);
        gap(); send(4'hF); gap(); send(4'hE);
        // Further misses to saturate the counter, then clear sticky.
        send(4'h5); send(4'h5);
        send(4'h0); send(4'h1); send(4'h3); send(4'h7); send(4'h5); send(4'hE);
        send(4'hC); send(4'h2);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        // Mid-lock reset.
        send(4'h0); send(4'h1); send(4'h3); send(4'h7); send(4'h2);
        step(1'b0, 1'b1, 4'hE);

        // Random phase: mostly-correct source with corruption, gaps and rare resets.
        src = 0;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : seq_tab[src];
            if ($urandom_range(0, 63) == 0) src = $urandom_range(0, 7);
            if (v) src = (src + 1) % 8;
            step(($urandom_range(0, 299) != 0), v, d, ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        cmp("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
